serial_receiver: RTL and testbench
==================================

# serial_receiver

Receive-side endpoint of the serial link driven by `serializer`. Samples the `serial_in`/`enable`/`start` bit stream, assembles DATA_WIDTH-bit words LSB first and buffers them in an optional FIFO. Presents the words on a valid/ready parallel output. Flags framing errors and overflow, and sits wherever the serial link leaves a chip or partition boundary.

## Interface
- `DATA_WIDTH`, 8: word width in bits. Must be at least 2.
- `FIFO_DEPTH`, 4: output buffer depth in words. 0 bypasses the FIFO and uses a single output register with no backpressure.
- `clk` input 1: sole clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `serial_in` input 1: data bit, sampled only when `enable`=1.
- `enable` input 1: qualifies `serial_in` on the current cycle. Gaps (`enable`=0) are allowed mid-word.
- `start` input 1: marks the current enabled bit as bit 0 of a new word. Ignored when `enable`=0.
- `parallel_out` output DATA_WIDTH: head-of-buffer word.
- `valid_out` output 1: `parallel_out` holds a word.
- `ready_in` input 1: consumer accepts the word. Ignored when FIFO_DEPTH=0.
- `frame_error` output 1: one-cycle pulse when a partial word is discarded.
- `overflow` output 1: one-cycle pulse when a completed word is dropped because the buffer is full.

## Operation
- Assembler FSM has two states, IDLE and SHIFT. A `bit_cnt` counter spans 0..DATA_WIDTH-1 and is $clog2(DATA_WIDTH) wide. A `shift_reg` is DATA_WIDTH wide.
- IDLE transitions:
  - `enable`&`start`: load bit 0 into `shift_reg[0]`, set `bit_cnt`=1, go to SHIFT.
  - `enable`&!`start`: the bit is stray. Discard it, stay in IDLE, no error.
- SHIFT transitions:
  - `enable`&!`start`: write bit to `shift_reg[bit_cnt]`, increment `bit_cnt`.
  - `enable`&!`start` on bit DATA_WIDTH-1: write the completed word to the buffer and return to IDLE.
  - `enable`&`start`: pulse `frame_error`, discard the partial word, treat this bit as bit 0 of a new word, set `bit_cnt`=1, stay in SHIFT.
  - `enable`=0: hold all state.
- Buffer with FIFO_DEPTH>0:
  - Push happens on word completion.
  - Pop happens when `valid_out`&`ready_in`.
  - If full and no pop this cycle, drop the completed word and pulse `overflow`. Buffer contents stay unchanged.
  - If full with a simultaneous pop, accept the push and do not pulse `overflow`.
  - Words emerge in arrival order.
- Buffer with FIFO_DEPTH=0:
  - A completed word loads the output register and `valid_out` is high for exactly one cycle.
  - `ready_in` is ignored.
  - `overflow` never asserts.
- Reset mid-word discards the partial word and empties the buffer.

## Timing
- Reset values:
  - `parallel_out`=0, `valid_out`=0, `frame_error`=0, `overflow`=0.
  - FSM in IDLE, `bit_cnt`=0, FIFO empty.
- Latency:
  - Bit 0 with `start` arrives at cycle t, with no gaps. Last bit arrives at t+DATA_WIDTH-1.
  - `valid_out` is 1 at cycle t+DATA_WIDTH when the buffer was empty, for any depth.
  - Each cycle with `enable`=0 inside the word adds one cycle.
- `frame_error` and `overflow` are registered. Each asserts in the cycle after the offending input cycle.
- Handshake:
  - `parallel_out` is stable while `valid_out`&!`ready_in`.
  - `valid_out` never deasserts without a pop.
  - The next word appears the cycle after a pop if one is buffered.
- Throughput is back-to-back words with no idle cycle between the last bit and the next `start`. Sustained rate is one word per DATA_WIDTH enabled cycles.

## Structure
- A shared package `serdes_pkg` holds:
  - the FSM state typedef `rx_state_t` (IDLE, SHIFT);
  - `bit_cnt` width derivation via localparam function `cnt_w(DATA_WIDTH)`.
- `serializer` uses the same package for its framing definitions.
- Sub-module: reuse the existing `fifo` (write_valid/write_ready/read_valid/read_ready, full/empty), instantiated under a generate on FIFO_DEPTH>0.
- The FSM, shift register and FIFO_DEPTH=0 output register stay in this module.

## Test plan
- Nominal word:
  - Stimulus: DATA_WIDTH=8, FIFO_DEPTH=4. Send 0xA5 LSB first with `start` on bit 0 at cycle 10, `ready_in`=1.
  - Response: `valid_out`=1 with `parallel_out`=0xA5 at cycle 18, for one cycle.
- Gapped word:
  - Stimulus: send 0x3C with `enable`=0 for 3 cycles after bit 4.
  - Response: `valid_out` at cycle t+11 with 0x3C, and no `frame_error`.
- Framing error:
  - Stimulus: send 3 bits, then re-`start` with 0x81.
  - Response: `frame_error` pulses once. The only word delivered is 0x81.
- Backpressure and overflow:
  - Stimulus: `ready_in`=0, send 5 words 0x01..0x05 back-to-back.
  - Response: `overflow` pulses once, after word 5.
  - Stimulus: then raise `ready_in`.
  - Response: pops 0x01..0x04 on consecutive cycles.
- Full with simultaneous pop:
  - Stimulus: 4 words buffered, word 5 completes in the same cycle as a pop.
  - Response: no `overflow`. Output sequence is 0x01..0x05.
- Bypass and reset:
  - Stimulus: FIFO_DEPTH=0, two back-to-back words 0x11, 0x22.
  - Response: two 1-cycle `valid_out` pulses 8 cycles apart.
  - Stimulus: `rst_n`=0 mid-third word.
  - Response: all outputs 0 next cycle, and no word from the partial bits.

Source files
------------

// File: rtl/serdes_pkg.sv
// Framing definitions shared by the serializer and serial_receiver endpoints.
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // Bit-counter width for a word of the given size; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Serial-link input and valid/ready parallel output of the receiver, plus its status pulses.
interface serial_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  serial_in;
    logic                  enable;
    logic                  start;
    logic [DATA_WIDTH-1:0] parallel_out;
    logic                  valid_out;
    logic                  ready_in;
    logic                  frame_error;
    logic                  overflow;

    modport master (
        output serial_in, enable, start, ready_in,
        input  parallel_out, valid_out, frame_error, overflow
    );

    modport slave (
        input  serial_in, enable, start, ready_in,
        output parallel_out, valid_out, frame_error, overflow
    );
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO; a push is accepted when full if a pop happens in the same cycle.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_valid,
    output logic             write_ready,
    input  logic [WIDTH-1:0] write_data,
    output logic             read_valid,
    input  logic             read_ready,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign read_valid  = !empty;
    assign pop         = read_valid && read_ready;
    assign write_ready = !full || pop;
    assign push        = write_valid && write_ready;
    assign read_data   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end
endmodule

// File: rtl/serial_receiver.sv
// Serial-link receive endpoint: assembles LSB-first words and presents them on a valid/ready
// output, either through a FIFO or (FIFO_DEPTH=0) a single one-cycle output register.
module serial_receiver
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_receiver_if.slave   bus
);
    localparam int CW = cnt_w(DATA_WIDTH);

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, word_data;
    logic                  word_done;
    logic                  frame_error_q, frame_error_d;
    logic                  overflow_q, overflow_d;

    always_comb begin
        state_d                   = state_q;
        bit_cnt_d                 = bit_cnt_q;
        shift_d                   = shift_q;
        frame_error_d             = 1'b0;
        word_done                 = 1'b0;
        word_data                 = shift_q;
        word_data[DATA_WIDTH-1]   = bus.serial_in;

        case (state_q)
            IDLE: begin
                // Enabled bits without start are stray and silently dropped.
                if (bus.enable && bus.start) begin
                    shift_d    = '0;
                    shift_d[0] = bus.serial_in;
                    bit_cnt_d  = CW'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.enable) begin
                    if (bus.start) begin
                        frame_error_d = 1'b1;
                        shift_d       = '0;
                        shift_d[0]    = bus.serial_in;
                        bit_cnt_d     = CW'(1);
                    end else if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        word_done = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        shift_d[bit_cnt_q] = bus.serial_in;
                        bit_cnt_d          = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.frame_error = frame_error_q;
    assign bus.overflow    = overflow_q;

    generate
        if (FIFO_DEPTH > 0) begin : g_fifo
            logic                  push_ready, head_valid, fifo_full, fifo_empty;
            logic                  unused_fifo;
            logic [DATA_WIDTH-1:0] head_data;

            fifo #(
                .WIDTH (DATA_WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk         (clk),
                .rst_n       (rst_n),
                .write_valid (word_done),
                .write_ready (push_ready),
                .write_data  (word_data),
                .read_valid  (head_valid),
                .read_ready  (bus.ready_in),
                .read_data   (head_data),
                .full        (fifo_full),
                .empty       (fifo_empty)
            );

            // Memory is not reset, so the output is forced to zero while nothing is buffered.
            assign bus.valid_out    = head_valid;
            assign bus.parallel_out = head_valid ? head_data : '0;
            assign overflow_d       = word_done && !push_ready;
            assign unused_fifo      = fifo_full ^ fifo_empty;
        end else begin : g_bypass
            logic [DATA_WIDTH-1:0] out_q;
            logic                  out_valid_q;
            logic                  unused_ready;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_q       <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= word_done;
                    if (word_done) begin
                        out_q <= word_data;
                    end
                end
            end

            assign bus.valid_out    = out_valid_q;
            assign bus.parallel_out = out_q;
            assign overflow_d       = 1'b0;
            assign unused_ready     = bus.ready_in;
        end
    endgenerate
endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench: a FIFO_DEPTH=4 receiver and a FIFO_DEPTH=0 receiver fed the same serial stream.
module tb_serial_receiver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser = 1'b0, en = 1'b0, st = 1'b0, rdy = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    serial_receiver_if #(.DATA_WIDTH(8)) ifa ();
    serial_receiver_if #(.DATA_WIDTH(8)) ifb ();

    assign ifa.serial_in = ser;
    assign ifa.enable    = en;
    assign ifa.start     = st;
    assign ifa.ready_in  = rdy;
    assign ifb.serial_in = ser;
    assign ifb.enable    = en;
    assign ifb.start     = st;
    assign ifb.ready_in  = rdy;

    serial_receiver #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
    serial_receiver #(.DATA_WIDTH(8), .FIFO_DEPTH(0)) dut_byp (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation records taken mid-cycle.
    int         fe_cnt = 0;
    int         ovf_cnt = 0;
    logic [7:0] popq[$];
    logic [7:0] byd[$];
    int         byc[$];

    always @(negedge clk) begin
        if (ifa.frame_error) fe_cnt++;
        if (ifa.overflow) ovf_cnt++;
        if (ifa.valid_out && rdy) popq.push_back(ifa.parallel_out);
        if (ifb.valid_out) begin
            byd.push_back(ifb.parallel_out);
            byc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        ser = b;
        en  = 1'b1;
        st  = s;
        tick();
        en  = 1'b0;
        st  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i], i == 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (ifa.valid_out !== 1'b0 || ifa.parallel_out !== 8'h00) begin
            errs++;
            $display("FAIL reset_out: valid=%b data=%h, want 0/00", ifa.valid_out, ifa.parallel_out);
        end
        checks++;
        if (ifa.frame_error !== 1'b0 || ifa.overflow !== 1'b0) begin
            errs++;
            $display("FAIL reset_flags: fe=%b ovf=%b, want 0/0", ifa.frame_error, ifa.overflow);
        end
        checks++;
        if (ifb.valid_out !== 1'b0 || ifb.parallel_out !== 8'h00) begin
            errs++;
            $display("FAIL reset_byp: valid=%b data=%h, want 0/00", ifb.valid_out, ifb.parallel_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        int base, fe0;
        base = popq.size();
        fe0  = fe_cnt;
        rdy  = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(i == 0 ? 1'b1 : ((8'hA5 >> i) & 1) != 0, i == 0);
        checks++;
        if (ifa.valid_out !== 1'b0) begin
            errs++;
            $display("FAIL nominal_early: valid=%b before last bit, want 0", ifa.valid_out);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (ifa.valid_out !== 1'b1 || ifa.parallel_out !== 8'hA5) begin
            errs++;
            $display("FAIL nominal_word: valid=%b data=%h, want 1/a5", ifa.valid_out, ifa.parallel_out);
        end
        tick();
        checks++;
        if (ifa.valid_out !== 1'b0 || popq.size() != base + 1 || fe_cnt != fe0) begin
            errs++;
            $display("FAIL nominal_pulse: valid=%b pops=%0d fe=%0d, want 0/1/0",
                     ifa.valid_out, popq.size() - base, fe_cnt - fe0);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        int fe0;
        w   = 8'h3C;
        fe0 = fe_cnt;
        for (int i = 0; i < 5; i++) send_bit(w[i], i == 0);
        repeat (3) tick();
        send_bit(w[5], 1'b0);
        send_bit(w[6], 1'b0);
        checks++;
        if (ifa.valid_out !== 1'b0) begin
            errs++;
            $display("FAIL gapped_early: valid=%b before last bit, want 0", ifa.valid_out);
        end
        send_bit(w[7], 1'b0);
        checks++;
        if (ifa.valid_out !== 1'b1 || ifa.parallel_out !== 8'h3C) begin
            errs++;
            $display("FAIL gapped_word: valid=%b data=%h, want 1/3c", ifa.valid_out, ifa.parallel_out);
        end
        tick();
        checks++;
        if (fe_cnt != fe0) begin
            errs++;
            $display("FAIL gapped_fe: frame errors=%0d, want 0", fe_cnt - fe0);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] w;
        int base, fe0;
        w    = 8'h81;
        base = popq.size();
        fe0  = fe_cnt;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(w[0], 1'b1);
        checks++;
        if (ifa.frame_error !== 1'b1) begin
            errs++;
            $display("FAIL frame_pulse: frame_error=%b after restart, want 1", ifa.frame_error);
        end
        for (int i = 1; i < 8; i++) send_bit(w[i], 1'b0);
        checks++;
        if (ifa.valid_out !== 1'b1 || ifa.parallel_out !== 8'h81) begin
            errs++;
            $display("FAIL frame_word: valid=%b data=%h, want 1/81", ifa.valid_out, ifa.parallel_out);
        end
        tick();
        checks++;
        if (fe_cnt != fe0 + 1 || popq.size() != base + 1 || popq[base] !== 8'h81) begin
            errs++;
            $display("FAIL frame_count: fe=%0d pops=%0d, want 1/1 word 81",
                     fe_cnt - fe0, popq.size() - base);
        end
    endtask

    task automatic test_overflow();
        int ovf0;
        ovf0 = ovf_cnt;
        rdy  = 1'b0;
        for (int k = 1; k <= 5; k++) send_word(8'(k));
        checks++;
        if (ifa.overflow !== 1'b1) begin
            errs++;
            $display("FAIL ovf_pulse: overflow=%b after word 5, want 1", ifa.overflow);
        end
        checks++;
        if (ifa.valid_out !== 1'b1 || ifa.parallel_out !== 8'h01) begin
            errs++;
            $display("FAIL ovf_hold: valid=%b data=%h, want 1/01", ifa.valid_out, ifa.parallel_out);
        end
        rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (ifa.valid_out !== 1'b1 || ifa.parallel_out !== 8'(k)) begin
                errs++;
                $display("FAIL ovf_pop%0d: valid=%b data=%h, want 1/%h", k, ifa.valid_out, ifa.parallel_out, 8'(k));
            end
            tick();
        end
        checks++;
        if (ifa.valid_out !== 1'b0 || ovf_cnt != ovf0 + 1) begin
            errs++;
            $display("FAIL ovf_drain: valid=%b overflows=%0d, want 0/1", ifa.valid_out, ovf_cnt - ovf0);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] w;
        int base, ovf0;
        base = popq.size();
        ovf0 = ovf_cnt;
        rdy  = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(8'(k));
        w = 8'h05;
        for (int i = 0; i < 7; i++) send_bit(w[i], i == 0);
        rdy = 1'b1;
        send_bit(w[7], 1'b0);
        checks++;
        if (ifa.overflow !== 1'b0 || ifa.parallel_out !== 8'h02) begin
            errs++;
            $display("FAIL fullpop_ovf: overflow=%b head=%h, want 0/02", ifa.overflow, ifa.parallel_out);
        end
        repeat (5) tick();
        checks++;
        if (popq.size() != base + 5 || ovf_cnt != ovf0) begin
            errs++;
            $display("FAIL fullpop_count: pops=%0d overflows=%0d, want 5/0", popq.size() - base, ovf_cnt - ovf0);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (popq[base + k] !== 8'(k + 1)) begin
                    errs++;
                    $display("FAIL fullpop_order%0d: got %h, want %h", k, popq[base + k], 8'(k + 1));
                end
            end
        end
    endtask

    task automatic test_bypass_reset();
        int bbase, pbase;
        bbase = byd.size();
        rdy   = 1'b0;
        send_word(8'h11);
        checks++;
        if (ifb.valid_out !== 1'b1 || ifb.parallel_out !== 8'h11) begin
            errs++;
            $display("FAIL byp_word1: valid=%b data=%h, want 1/11", ifb.valid_out, ifb.parallel_out);
        end
        send_word(8'h22);
        checks++;
        if (ifb.valid_out !== 1'b1 || ifb.parallel_out !== 8'h22) begin
            errs++;
            $display("FAIL byp_word2: valid=%b data=%h, want 1/22", ifb.valid_out, ifb.parallel_out);
        end
        tick();
        checks++;
        if (byd.size() != bbase + 2) begin
            errs++;
            $display("FAIL byp_pulses: pulse cycles=%0d, want 2", byd.size() - bbase);
        end else if (byc[bbase + 1] - byc[bbase] != 8 || byd[bbase] !== 8'h11 || byd[bbase + 1] !== 8'h22) begin
            errs++;
            $display("FAIL byp_spacing: gap=%0d words=%h,%h, want 8/11,22",
                     byc[bbase + 1] - byc[bbase], byd[bbase], byd[bbase + 1]);
        end
        checks++;
        if (ifa.valid_out !== 1'b1 || ifa.parallel_out !== 8'h11) begin
            errs++;
            $display("FAIL byp_fifo_held: valid=%b data=%h, want 1/11", ifa.valid_out, ifa.parallel_out);
        end
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        checks++;
        if (ifa.valid_out !== 1'b0 || ifa.parallel_out !== 8'h00 ||
            ifb.valid_out !== 1'b0 || ifb.parallel_out !== 8'h00 ||
            ifa.frame_error !== 1'b0 || ifa.overflow !== 1'b0) begin
            errs++;
            $display("FAIL midreset_out: a=%b/%h b=%b/%h fe=%b ovf=%b, want all 0",
                     ifa.valid_out, ifa.parallel_out, ifb.valid_out, ifb.parallel_out,
                     ifa.frame_error, ifa.overflow);
        end
        rst_n = 1'b1;
        rdy   = 1'b1;
        pbase = popq.size();
        bbase = byd.size();
        for (int i = 3; i < 8; i++) send_bit(1'b1, 1'b0);
        repeat (3) tick();
        checks++;
        if (popq.size() != pbase || byd.size() != bbase || ifa.valid_out !== 1'b0) begin
            errs++;
            $display("FAIL midreset_partial: pops=%0d byp=%0d valid=%b, want 0/0/0",
                     popq.size() - pbase, byd.size() - bbase, ifa.valid_out);
        end
    endtask

    initial begin
        #1;
        test_reset();
        repeat (4) tick();
        test_nominal();
        test_gapped();
        test_frame_error();
        test_overflow();
        test_full_pop();
        test_bypass_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
